// File: rtl/mem_controller_rr.sv
// mem_controller_rr
//   Multi-channel memory controller. Consumer read/write requests are
//   arbitrated round-robin onto NUM_CHANNELS memory channels; responses are
//   relayed back with a valid/ready handshake. Each memory wait can be bounded
//   by TIMEOUT_CYCLES, and a timed-out channel raises a sticky error flag.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   consumer_read_*            per-consumer read request / response (packed)
//   consumer_write_*           per-consumer write request / done (packed)
//   mem_read_*                 per-channel read request / response (packed)
//   mem_write_*                per-channel write request / ack (packed)
//   timeout_error              per-channel sticky timeout flag
module mem_controller_rr #(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 16,
    parameter int NUM_CONSUMERS  = 4,
    parameter int NUM_CHANNELS   = 1,
    parameter int WRITE_ENABLE   = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready,
    output logic [NUM_CHANNELS-1:0]            timeout_error
);

    localparam int CW = $clog2(NUM_CONSUMERS);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_RELAYING,
        WRITE_RELAYING
    } state_t;

    // Channel state
    state_t                 state_reg     [NUM_CHANNELS];
    logic [CW-1:0]          cons_reg      [NUM_CHANNELS];
    logic [TW-1:0]          count_reg     [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   mem_raddr_reg [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   mem_waddr_reg [NUM_CHANNELS];
    logic [DATA_BITS-1:0]   mem_wdata_reg [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] mem_rvalid_reg;
    logic [NUM_CHANNELS-1:0] mem_wvalid_reg;
    logic [NUM_CHANNELS-1:0] timeout_reg;

    // Consumer state
    logic [NUM_CONSUMERS-1:0] in_service_reg;
    logic [NUM_CONSUMERS-1:0] cons_rready_reg;
    logic [NUM_CONSUMERS-1:0] cons_wready_reg;
    logic [DATA_BITS-1:0]     cons_rdata_reg [NUM_CONSUMERS];
    logic [CW-1:0]            rr_ptr_reg;

    // Unpacked views of the packed buses
    logic [ADDR_BITS-1:0] c_raddr [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0] c_waddr [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] c_wdata [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] m_rdata [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] timed_out;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_cons
            assign c_raddr[gi] = consumer_read_address[gi*ADDR_BITS +: ADDR_BITS];
            assign c_waddr[gi] = consumer_write_address[gi*ADDR_BITS +: ADDR_BITS];
            assign c_wdata[gi] = consumer_write_data[gi*DATA_BITS +: DATA_BITS];
            assign consumer_read_data[gi*DATA_BITS +: DATA_BITS] = cons_rdata_reg[gi];
        end
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            assign m_rdata[gi] = mem_read_data[gi*DATA_BITS +: DATA_BITS];
            assign mem_read_address[gi*ADDR_BITS +: ADDR_BITS]  = mem_raddr_reg[gi];
            assign mem_write_address[gi*ADDR_BITS +: ADDR_BITS] = mem_waddr_reg[gi];
            assign mem_write_data[gi*DATA_BITS +: DATA_BITS]    = mem_wdata_reg[gi];
            // Fires on the WAITING edge at which the count would reach TIMEOUT_CYCLES
            assign timed_out[gi] = (TIMEOUT_CYCLES > 0) &&
                                   (count_reg[gi] == TW'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

    assign mem_read_valid       = mem_rvalid_reg;
    assign mem_write_valid      = mem_wvalid_reg;
    assign timeout_error        = timeout_reg;
    assign consumer_read_ready  = cons_rready_reg;
    assign consumer_write_ready = cons_wready_reg;

    // Write requests are invisible to a read-only controller
    logic [NUM_CONSUMERS-1:0] write_req;
    logic [NUM_CONSUMERS-1:0] eligible;
    assign write_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
    assign eligible  = (consumer_read_valid | write_req) & ~in_service_reg;

    // Arbitration: IDLE channels in ascending order each take the first
    // eligible, not-yet-taken consumer at or after rr_ptr (wrapping).
    logic [NUM_CHANNELS-1:0]  grant;
    logic [NUM_CHANNELS-1:0]  grant_read;
    logic [CW-1:0]            grant_idx [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] taken;
    logic [CW-1:0]            rr_ptr_next;
    logic [CW:0]              arb_sum;
    logic [CW-1:0]            arb_idx;

    always_comb begin
        grant       = '0;
        grant_read  = '0;
        taken       = '0;
        rr_ptr_next = rr_ptr_reg;
        arb_sum     = '0;
        arb_idx     = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            grant_idx[i] = '0;
            if (state_reg[i] == IDLE) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    arb_sum = {1'b0, rr_ptr_reg} + (CW+1)'(k);
                    if (arb_sum >= (CW+1)'(NUM_CONSUMERS))
                        arb_sum = arb_sum - (CW+1)'(NUM_CONSUMERS);
                    arb_idx = arb_sum[CW-1:0];
                    if (!grant[i] && eligible[arb_idx] && !taken[arb_idx]) begin
                        grant[i]      = 1'b1;
                        grant_idx[i]  = arb_idx;
                        grant_read[i] = consumer_read_valid[arb_idx];
                        taken[arb_idx] = 1'b1;
                        // Highest channel granting overwrites: pointer follows the last grant
                        rr_ptr_next = (arb_idx == CW'(NUM_CONSUMERS - 1)) ? '0 : arb_idx + CW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg      <= '0;
            in_service_reg  <= '0;
            cons_rready_reg <= '0;
            cons_wready_reg <= '0;
            mem_rvalid_reg  <= '0;
            mem_wvalid_reg  <= '0;
            timeout_reg     <= '0;
            for (int j = 0; j < NUM_CONSUMERS; j++)
                cons_rdata_reg[j] <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_reg[i]     <= IDLE;
                cons_reg[i]      <= '0;
                count_reg[i]     <= '0;
                mem_raddr_reg[i] <= '0;
                mem_waddr_reg[i] <= '0;
                mem_wdata_reg[i] <= '0;
            end
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                case (state_reg[i])
                    IDLE: begin
                        if (grant[i]) begin
                            cons_reg[i]  <= grant_idx[i];
                            count_reg[i] <= '0;
                            in_service_reg[grant_idx[i]] <= 1'b1;
                            if (grant_read[i]) begin
                                mem_rvalid_reg[i] <= 1'b1;
                                mem_raddr_reg[i]  <= c_raddr[grant_idx[i]];
                                state_reg[i]      <= READ_WAITING;
                            end else begin
                                mem_wvalid_reg[i] <= 1'b1;
                                mem_waddr_reg[i]  <= c_waddr[grant_idx[i]];
                                mem_wdata_reg[i]  <= c_wdata[grant_idx[i]];
                                state_reg[i]      <= WRITE_WAITING;
                            end
                        end
                    end
                    READ_WAITING: begin
                        if (mem_read_ready[i] || timed_out[i]) begin
                            mem_rvalid_reg[i]            <= 1'b0;
                            cons_rready_reg[cons_reg[i]] <= 1'b1;
                            cons_rdata_reg[cons_reg[i]]  <= mem_read_ready[i] ? m_rdata[i] : '0;
                            if (!mem_read_ready[i])
                                timeout_reg[i] <= 1'b1;
                            state_reg[i] <= READ_RELAYING;
                        end else begin
                            count_reg[i] <= count_reg[i] + TW'(1);
                        end
                    end
                    WRITE_WAITING: begin
                        if (mem_write_ready[i] || timed_out[i]) begin
                            mem_wvalid_reg[i]            <= 1'b0;
                            cons_wready_reg[cons_reg[i]] <= 1'b1;
                            if (!mem_write_ready[i])
                                timeout_reg[i] <= 1'b1;
                            state_reg[i] <= WRITE_RELAYING;
                        end else begin
                            count_reg[i] <= count_reg[i] + TW'(1);
                        end
                    end
                    READ_RELAYING: begin
                        if (!consumer_read_valid[cons_reg[i]]) begin
                            cons_rready_reg[cons_reg[i]] <= 1'b0;
                            in_service_reg[cons_reg[i]]  <= 1'b0;
                            state_reg[i]                 <= IDLE;
                        end
                    end
                    WRITE_RELAYING: begin
                        if (!consumer_write_valid[cons_reg[i]]) begin
                            cons_wready_reg[cons_reg[i]] <= 1'b0;
                            in_service_reg[cons_reg[i]]  <= 1'b0;
                            state_reg[i]                 <= IDLE;
                        end
                    end
                    default: state_reg[i] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_controller_rr.sv
// Directed testbench for mem_controller_rr.
//   u_a: 1 channel, writes enabled, TIMEOUT_CYCLES=5
//   u_b: 2 channels, read-only, no timeout
module tb_mem_controller_rr;
    localparam int AB = 8;
    localparam int DB = 16;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Instance A signals
    logic [NC-1:0]    a_crv, a_crr, a_cwv, a_cwr;
    logic [NC*AB-1:0] a_cra, a_cwa;
    logic [NC*DB-1:0] a_crd, a_cwd;
    logic [0:0]       a_mrv, a_mrr, a_mwv, a_mwr, a_terr;
    logic [AB-1:0]    a_mra, a_mwa;
    logic [DB-1:0]    a_mrd, a_mwd;

    // Instance B signals
    logic [NC-1:0]    b_crv, b_crr, b_cwv, b_cwr;
    logic [NC*AB-1:0] b_cra, b_cwa;
    logic [NC*DB-1:0] b_crd, b_cwd;
    logic [1:0]       b_mrv, b_mrr, b_mwv, b_mwr, b_terr;
    logic [2*AB-1:0]  b_mra, b_mwa;
    logic [2*DB-1:0]  b_mrd, b_mwd;

    mem_controller_rr #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
        .NUM_CHANNELS(1), .WRITE_ENABLE(1), .TIMEOUT_CYCLES(5)
    ) u_a (
        .clk(clk), .reset(reset),
        .consumer_read_valid(a_crv), .consumer_read_address(a_cra),
        .consumer_read_ready(a_crr), .consumer_read_data(a_crd),
        .consumer_write_valid(a_cwv), .consumer_write_address(a_cwa),
        .consumer_write_data(a_cwd), .consumer_write_ready(a_cwr),
        .mem_read_valid(a_mrv), .mem_read_address(a_mra),
        .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
        .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
        .mem_write_data(a_mwd), .mem_write_ready(a_mwr),
        .timeout_error(a_terr)
    );

    mem_controller_rr #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
        .NUM_CHANNELS(2), .WRITE_ENABLE(0), .TIMEOUT_CYCLES(0)
    ) u_b (
        .clk(clk), .reset(reset),
        .consumer_read_valid(b_crv), .consumer_read_address(b_cra),
        .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
        .consumer_write_valid(b_cwv), .consumer_write_address(b_cwa),
        .consumer_write_data(b_cwd), .consumer_write_ready(b_cwr),
        .mem_read_valid(b_mrv), .mem_read_address(b_mra),
        .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
        .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
        .mem_write_data(b_mwd), .mem_write_ready(b_mwr),
        .timeout_error(b_terr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_crv = '0; a_cra = '0; a_cwv = '0; a_cwa = '0; a_cwd = '0;
        a_mrr = '0; a_mrd = '0; a_mwr = '0;
        b_crv = '0; b_cra = '0; b_cwv = '0; b_cwa = '0; b_cwd = '0;
        b_mrr = '0; b_mrd = '0; b_mwr = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({a_mrv, a_mwv, a_crr, a_cwr, a_terr} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset_a_ctrl: got %b expected 0", {a_mrv, a_mwv, a_crr, a_cwr, a_terr});
        end
        vectors++;
        if (a_crd !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_a_data: got %h expected 0", a_crd);
        end
        vectors++;
        if ({b_mrv, b_mwv, b_crr, b_cwr, b_terr} !== 14'b0) begin
            miscompares++;
            $display("FAIL reset_b_ctrl: got %b expected 0", {b_mrv, b_mwv, b_crr, b_cwr, b_terr});
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_single_read();
        do_reset();
        a_crv[2] = 1'b1;
        a_cra[2*AB +: AB] = 8'h10;
        tick();
        vectors++;
        if (a_mrv !== 1'b1 || a_mra !== 8'h10 || a_crr !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_grant: mrv=%b mra=%h crr=%b expected 1 10 0000", a_mrv, a_mra, a_crr);
        end
        tick();
        tick();
        vectors++;
        if (a_mrv !== 1'b1 || a_crr !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_wait: mrv=%b crr=%b expected 1 0000", a_mrv, a_crr);
        end
        a_mrr = 1'b1;
        a_mrd = 16'h1234;
        tick();
        vectors++;
        if (a_crr !== 4'b0100 || a_crd[2*DB +: DB] !== 16'h1234 || a_mrv !== 1'b0) begin
            miscompares++;
            $display("FAIL single_resp: crr=%b data=%h mrv=%b expected 0100 1234 0",
                     a_crr, a_crd[2*DB +: DB], a_mrv);
        end
        a_mrr = 1'b0;
        a_crv[2] = 1'b0;
        tick();
        vectors++;
        if (a_crr !== 4'b0000 || a_crd[2*DB +: DB] !== 16'h1234) begin
            miscompares++;
            $display("FAIL single_release: crr=%b data=%h expected 0000 1234", a_crr, a_crd[2*DB +: DB]);
        end
        $display("read c2 addr 10 data 1234");
    endtask

    task automatic test_round_robin();
        int exp;
        do_reset();
        for (int j = 0; j < NC; j++)
            a_cra[j*AB +: AB] = 8'h40 + 8'(j);
        a_crv = 4'b1111;
        tick();
        for (int n = 0; n < 8; n++) begin
            exp = n % NC;
            vectors++;
            if (a_mrv !== 1'b1 || a_mra !== 8'h40 + 8'(exp)) begin
                miscompares++;
                $display("FAIL rr_grant_%0d: mrv=%b mra=%h expected 1 %h", n, a_mrv, a_mra, 8'h40 + 8'(exp));
            end
            a_mrr = 1'b1;
            a_mrd = 16'h0100 + 16'(n);
            tick();
            vectors++;
            if (a_crr !== (4'b0001 << exp) || a_crd[exp*DB +: DB] !== 16'h0100 + 16'(n)) begin
                miscompares++;
                $display("FAIL rr_resp_%0d: crr=%b data=%h expected %b %h", n, a_crr,
                         a_crd[exp*DB +: DB], 4'b0001 << exp, 16'h0100 + 16'(n));
            end
            a_mrr = 1'b0;
            a_crv[exp] = 1'b0;
            tick();
            a_crv[exp] = 1'b1;
            tick();
            $display("rr read %0d served c%0d", n, exp);
        end
    endtask

    task automatic test_read_write();
        do_reset();
        a_cwv[0] = 1'b1;
        a_cwa[0 +: AB] = 8'h20;
        a_cwd[0 +: DB] = 16'hBEEF;
        tick();
        vectors++;
        if (a_mwv !== 1'b1 || a_mwa !== 8'h20 || a_mwd !== 16'hBEEF || a_mrv !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_grant: mwv=%b mwa=%h mwd=%h mrv=%b expected 1 20 beef 0",
                     a_mwv, a_mwa, a_mwd, a_mrv);
        end
        a_mwr = 1'b1;
        tick();
        vectors++;
        if (a_cwr !== 4'b0001 || a_mwv !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_done: cwr=%b mwv=%b expected 0001 0", a_cwr, a_mwv);
        end
        a_mwr = 1'b0;
        a_cwv[0] = 1'b0;
        tick();
        vectors++;
        if (a_cwr !== 4'b0000) begin
            miscompares++;
            $display("FAIL wr_release: cwr=%b expected 0000", a_cwr);
        end
        a_crv[0] = 1'b1;
        a_cra[0 +: AB] = 8'h20;
        tick();
        a_mrr = 1'b1;
        a_mrd = 16'hBEEF;
        tick();
        vectors++;
        if (a_crr !== 4'b0001 || a_crd[0 +: DB] !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL wr_readback: crr=%b data=%h expected 0001 beef", a_crr, a_crd[0 +: DB]);
        end
        a_mrr = 1'b0;
        a_crv[0] = 1'b0;
        tick();
        $display("write c0 addr 20 data beef, read back");
    endtask

    task automatic test_parallel_grant();
        do_reset();
        b_crv = 4'b1010;
        b_cra[1*AB +: AB] = 8'h11;
        b_cra[3*AB +: AB] = 8'h33;
        tick();
        vectors++;
        if (b_mrv !== 2'b11 || b_mra !== 16'h3311) begin
            miscompares++;
            $display("FAIL par_grant: mrv=%b mra=%h expected 11 3311", b_mrv, b_mra);
        end
        b_mrr = 2'b11;
        b_mrd = {16'h3333, 16'h1111};
        tick();
        vectors++;
        if (b_crr !== 4'b1010 || b_crd[1*DB +: DB] !== 16'h1111 || b_crd[3*DB +: DB] !== 16'h3333) begin
            miscompares++;
            $display("FAIL par_resp: crr=%b d1=%h d3=%h expected 1010 1111 3333",
                     b_crr, b_crd[1*DB +: DB], b_crd[3*DB +: DB]);
        end
        b_mrr = 2'b00;
        b_crv = 4'b0000;
        tick();
        // rr_ptr must be back at 0, so consumers 0 and 1 win next
        for (int j = 0; j < NC; j++)
            b_cra[j*AB +: AB] = 8'h50 + 8'(j);
        b_crv = 4'b1111;
        tick();
        vectors++;
        if (b_mrv !== 2'b11 || b_mra !== 16'h5150) begin
            miscompares++;
            $display("FAIL par_rrptr: mrv=%b mra=%h expected 11 5150", b_mrv, b_mra);
        end
        $display("parallel reads c1,c3 then c0,c1");
    endtask

    task automatic test_write_disabled();
        do_reset();
        b_cwv[0] = 1'b1;
        b_cwa[0 +: AB] = 8'h20;
        b_cwd[0 +: DB] = 16'hBEEF;
        tick();
        tick();
        tick();
        vectors++;
        if (b_mwv !== 2'b00 || b_cwr !== 4'b0000 || b_mrv !== 2'b00) begin
            miscompares++;
            $display("FAIL ro_write: mwv=%b cwr=%b mrv=%b expected 00 0000 00", b_mwv, b_cwr, b_mrv);
        end
        b_crv[0] = 1'b1;
        b_cra[0 +: AB] = 8'h22;
        tick();
        vectors++;
        if (b_mrv !== 2'b01 || b_mra[0 +: AB] !== 8'h22 || b_mwv !== 2'b00) begin
            miscompares++;
            $display("FAIL ro_read: mrv=%b mra=%h mwv=%b expected 01 22 00", b_mrv, b_mra[0 +: AB], b_mwv);
        end
        $display("read-only: write ignored, read granted");
    endtask

    task automatic test_timeout();
        do_reset();
        a_crv[0] = 1'b1;
        a_cra[0 +: AB] = 8'h30;
        tick();
        a_mrr = 1'b1;
        a_mrd = 16'hA5A5;
        tick();
        vectors++;
        if (a_crd[0 +: DB] !== 16'hA5A5) begin
            miscompares++;
            $display("FAIL to_pre: data=%h expected a5a5", a_crd[0 +: DB]);
        end
        a_mrr = 1'b0;
        a_crv[0] = 1'b0;
        tick();
        a_crv[0] = 1'b1;
        a_cra[0 +: AB] = 8'h31;
        tick();
        for (int c = 1; c <= 4; c++) begin
            tick();
            vectors++;
            if (a_crr !== 4'b0000 || a_mrv !== 1'b1 || a_terr !== 1'b0) begin
                miscompares++;
                $display("FAIL to_wait_%0d: crr=%b mrv=%b terr=%b expected 0000 1 0", c, a_crr, a_mrv, a_terr);
            end
        end
        tick();
        vectors++;
        if (a_crr !== 4'b0001 || a_crd[0 +: DB] !== 16'h0000 || a_terr !== 1'b1 || a_mrv !== 1'b0) begin
            miscompares++;
            $display("FAIL to_fire: crr=%b data=%h terr=%b mrv=%b expected 0001 0000 1 0",
                     a_crr, a_crd[0 +: DB], a_terr, a_mrv);
        end
        a_crv[0] = 1'b0;
        tick();
        a_crv[1] = 1'b1;
        a_cra[1*AB +: AB] = 8'h32;
        tick();
        a_mrr = 1'b1;
        a_mrd = 16'h7777;
        tick();
        vectors++;
        if (a_crd[1*DB +: DB] !== 16'h7777 || a_terr !== 1'b1 || a_crr !== 4'b0010) begin
            miscompares++;
            $display("FAIL to_sticky: data=%h terr=%b crr=%b expected 7777 1 0010",
                     a_crd[1*DB +: DB], a_terr, a_crr);
        end
        a_mrr = 1'b0;
        a_crv[1] = 1'b0;
        tick();
        $display("timeout read c0 addr 31, then read c1 data 7777");
    endtask

    task automatic test_reset_mid();
        a_crv[2] = 1'b1;
        a_cra[2*AB +: AB] = 8'h40;
        tick();
        vectors++;
        if (a_mrv !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_grant: mrv=%b expected 1", a_mrv);
        end
        tick();
        reset = 1'b1;
        a_crv = '0;
        tick();
        vectors++;
        if ({a_mrv, a_mwv, a_crr, a_cwr, a_terr} !== 11'b0 || a_crd !== 64'h0 || a_mra !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset: ctrl=%b data=%h mra=%h expected 0 0 0",
                     {a_mrv, a_mwv, a_crr, a_cwr, a_terr}, a_crd, a_mra);
        end
        reset = 1'b0;
        a_crv[3] = 1'b1;
        a_cra[3*AB +: AB] = 8'h44;
        tick();
        vectors++;
        if (a_mrv !== 1'b1 || a_mra !== 8'h44) begin
            miscompares++;
            $display("FAIL mid_regrant: mrv=%b mra=%h expected 1 44", a_mrv, a_mra);
        end
        a_mrr = 1'b1;
        a_mrd = 16'h4444;
        tick();
        vectors++;
        if (a_crr !== 4'b1000 || a_crd[3*DB +: DB] !== 16'h4444) begin
            miscompares++;
            $display("FAIL mid_resp: crr=%b data=%h expected 1000 4444", a_crr, a_crd[3*DB +: DB]);
        end
        a_mrr = 1'b0;
        a_crv[3] = 1'b0;
        tick();
        $display("reset mid-read, then read c3 data 4444");
    endtask

    task automatic test_timeout_same_cycle();
        do_reset();
        a_crv[0] = 1'b1;
        a_cra[0 +: AB] = 8'h60;
        tick();
        for (int c = 0; c < 4; c++)
            tick();
        a_mrr = 1'b1;
        a_mrd = 16'h5555;
        tick();
        vectors++;
        if (a_crr !== 4'b0001 || a_crd[0 +: DB] !== 16'h5555 || a_terr !== 1'b0) begin
            miscompares++;
            $display("FAIL to_same_cycle: crr=%b data=%h terr=%b expected 0001 5555 0",
                     a_crr, a_crd[0 +: DB], a_terr);
        end
        a_mrr = 1'b0;
        a_crv[0] = 1'b0;
        tick();
        $display("read c0 answered on timeout edge, data 5555");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_read_write();
        test_parallel_grant();
        test_write_disabled();
        test_timeout();
        test_reset_mid();
        test_timeout_same_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
